// File: rtl/matrix_scan_driver_if.sv
// Frame-in / pin-out bundle between the matrix logic (master) and the scan driver (slave).
interface matrix_scan_driver_if;
    logic        enable;
    logic [15:0] matrix;
    logic [3:0]  row_sel;
    logic [3:0]  col_drive;
    logic        frame_strobe;

    modport master (output enable, matrix, input row_sel, col_drive, frame_strobe);
    modport slave  (input enable, matrix, output row_sel, col_drive, frame_strobe);
endinterface

// File: rtl/matrix_scan_driver.sv
// Multiplexed 4x4 LED scanner: latches the frame once per scan and drives one row per CLK_DIV cycles.
// Outputs are registered (one cycle after state change); no backpressure, enable low blanks at the next edge.
module matrix_scan_driver #(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    matrix_scan_driver_if.slave bus
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

    state_e        state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    row_sel_q, row_sel_d;
    logic [3:0]    col_drive_q, col_drive_d;
    logic          strobe_q, strobe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= 2'd0;
            tick_q      <= '0;
            shadow_q    <= 16'h0000;
            row_sel_q   <= 4'b0000;
            col_drive_q <= 4'b0000;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            tick_q      <= tick_d;
            shadow_q    <= shadow_d;
            row_sel_q   <= row_sel_d;
            col_drive_q <= col_drive_d;
            strobe_q    <= strobe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        tick_d      = tick_q;
        shadow_d    = shadow_q;
        strobe_d    = 1'b0;
        row_sel_d   = 4'b0000;
        col_drive_d = 4'b0000;

        if (!bus.enable) begin
            state_d = IDLE;
            row_d   = 2'd0;
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    row_d    = 2'd0;
                    tick_d   = '0;
                    shadow_d = bus.matrix;
                    strobe_d = 1'b1;
                end
                BLANK: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TW'(BLANK_CYCLES - 1)) state_d = DRIVE;
                end
                DRIVE: begin
                    if (tick_q == TW'(CLK_DIV - 1)) begin
                        state_d = BLANK;
                        tick_d  = '0;
                        row_d   = row_q + 2'd1;
                        // Frame boundary: latch the next frame only after row 3 finishes.
                        if (row_q == 2'd3) begin
                            shadow_d = bus.matrix;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Registered outputs mirror the decode of the state being entered.
        if (state_d == DRIVE) begin
            row_sel_d   = 4'b0001 << row_d;
            col_drive_d = shadow_d[{row_d, 2'b00} +: 4];
        end
    end

    assign bus.row_sel      = row_sel_q;
    assign bus.col_drive    = col_drive_q;
    assign bus.frame_strobe = strobe_q;
endmodule

// File: doc/matrix_scan_driver.md
Name: matrix_scan_driver

Overview:
Takes the 16-bit logical LED frame (4x4, bit index = 4*row + col) produced by the matrix logic and drives a physical multiplexed 4x4 LED array. Scans one row at a time, with a blanking gap before each row to suppress ghosting. The frame is latched once per scan so each displayed frame is tear-free. Sits between the game/matrix logic and the board pins.

Parameters:
CLK_DIV, 1000, clock cycles per row period (>= 2)
BLANK_CYCLES, 16, cycles at the start of each row period with all drives off (1 <= BLANK_CYCLES < CLK_DIV)

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  asynchronous active-low reset
enable  input  1  scan enable; low forces display dark and idle
matrix  input  16  logical frame; bit 4*r+c = LED at row r, column c
row_sel  output  4  one-hot active-high row drive; bit r = row r
col_drive  output  4  active-high column drive for the selected row; bit c = column c
frame_strobe  output  1  one-cycle pulse when a new frame is latched

Behaviour:
- Reset is async on rst_n low. row_sel=0, col_drive=0, frame_strobe=0, state=IDLE, row=0, tick=0, shadow=0. No clock edge needed.
- State, row (2b), tick ($clog2(CLK_DIV) bits) and shadow (16b) are registers.
- All outputs are registered and equal the decode of the current state:
  - row_sel = onehot(row) in DRIVE, else 0.
  - col_drive = shadow[4*row+3 : 4*row] in DRIVE, else 0.
- IDLE: tick=0, row=0.
  - If enable=1, next cycle enters BLANK, shadow<=matrix, frame_strobe=1 in that first BLANK cycle.
- BLANK: tick increments each cycle.
  - At tick==BLANK_CYCLES-1, next state is DRIVE.
- DRIVE: tick increments each cycle.
  - At tick==CLK_DIV-1, next state is BLANK, tick<=0, row<=row+1 mod 4.
  - If row was 3 (wrap to 0): shadow<=matrix and frame_strobe=1 in the first BLANK cycle of row 0.
- Row period is exactly CLK_DIV cycles: BLANK ticks 0..BLANK_CYCLES-1, DRIVE ticks BLANK_CYCLES..CLK_DIV-1.
- Frame period is 4*CLK_DIV cycles. frame_strobe is high for exactly 1 cycle per frame.
- matrix is sampled only at frame load. Changes mid-frame never affect the rows of the current frame.
- enable low in any state:
  - next cycle state=IDLE, row=0, tick=0, outputs 0.
  - shadow is retained but is reloaded on re-enable.
  - enable high again: same behaviour as leaving IDLE (fresh load, strobe, row 0).
- Invariants:
  - popcount(row_sel) <= 1.
  - col_drive=0 whenever row_sel=0.
  - row_sel never changes directly from one row to another; at least BLANK_CYCLES zero cycles separate rows.
- Reset mid-row: outputs go to 0 asynchronously. After release, the block behaves as from IDLE.

Test Plan:
Use CLK_DIV=8 and BLANK_CYCLES=2 for all scenarios.
1. Hold rst_n=0 with matrix=16'hFFFF, enable=1 -> row_sel=0, col_drive=0, frame_strobe=0 throughout.
2. Load and scan 16'h8421:
   - Release reset with matrix=16'h8421, enable=1.
   - frame_strobe pulses in the first BLANK cycle; row_sel=0 for 2 cycles.
   - Then row_sel=0001/col_drive=0001 for 6 cycles, followed by 0010/0010, 0100/0100, 1000/1000, each preceded by 2 dark cycles.
3. Tear-free update:
   - Change matrix to 16'hFFFF during row 1 DRIVE.
   - Rows 1-3 still show 0010/0100/1000.
   - The next frame shows col_drive=1111 on every row.
   - frame_strobe pulses are exactly 32 cycles apart.
4. Enable drop and restart:
   - Deassert enable during row 2 DRIVE -> next cycle row_sel=0, col_drive=0, remains dark.
   - Reassert with matrix=16'h000F -> strobe, then row 0 shows col_drive=1111 and rows 1-3 show 0000.
5. Async reset mid-scan:
   - Pulse rst_n low between clock edges during row 3 DRIVE -> outputs 0 immediately.
   - After release, the scan restarts at row 0 with a fresh load.
6. Invariant checker over a 1000-cycle run with random matrix changes and random enable toggles:
   - row_sel is never multi-hot.
   - col_drive=0 whenever row_sel=0.
   - Every row transition has >= 2 dark cycles.
